ita_gelu_requant: RTL and testbench

Elastic two-stage requantizer downstream of the GELU activation unit. It converts each wide signed GELU result to a signed 8-bit activation using a per-beat multiplier, a rounding right shift and an additive offset, then saturates the result. It uses valid/ready handshaking on both sides and tags the final element of each tile with `last_o` for the output write-back path.

---
 rtl/ita_gelu_requant.sv | 155 +++++++++++++++
 tb/tb_ita_gelu_requant.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ita_gelu_requant.sv
`default_nettype none
// ============================================================================
// Module   : ita_gelu_requant
// Purpose  : Two-stage elastic requantizer (multiply, rounding shift, offset,
//            saturate) for GELU results, with tile framing on the output.
//            Optional macro ITA_GELU_REQUANT_SAT_COUNT_EN adds sat_count_o.
// Revision : 1.0  initial release
// ============================================================================
module ita_gelu_requant #(
    parameter int IN_WIDTH  = 26,
    parameter int OUT_WIDTH = 8,
    parameter int LEN_WIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic signed [IN_WIDTH-1:0]  data_i,
    input  logic        [7:0]           mult_i,
    input  logic        [4:0]           shift_i,
    input  logic signed [7:0]           add_i,
    input  logic        [LEN_WIDTH-1:0] tile_len_i,
`ifdef ITA_GELU_REQUANT_SAT_COUNT_EN
    output logic        [15:0]          sat_count_o,
`endif
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic signed [OUT_WIDTH-1:0] data_o,
    output logic                        last_o
);

    localparam int c_prod_w = IN_WIDTH + 9;
    localparam int c_sum_w  = c_prod_w + 2;
    localparam logic signed [c_sum_w-1:0] c_max =
        c_sum_w'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [c_sum_w-1:0] c_min = ~c_max;
    localparam logic        [c_prod_w:0]  c_one = (c_prod_w + 1)'(1);

    logic                        r_s1_valid;
    logic signed [c_prod_w-1:0]  r_s1_prod;
    logic        [4:0]           r_s1_shift;
    logic signed [7:0]           r_s1_add;
    logic                        r_s2_valid;
    logic signed [OUT_WIDTH-1:0] r_s2_data;
    logic        [LEN_WIDTH-1:0] r_cnt;

    logic                        w_s1_adv;
    logic                        w_s2_adv;
    logic                        w_in_hs;
    logic                        w_out_hs;
    logic signed [c_prod_w-1:0]  w_prod;
    logic signed [c_prod_w:0]    w_ext;
    logic        [c_prod_w:0]    w_rnd;
    logic signed [c_prod_w:0]    w_rsum;
    logic signed [c_prod_w:0]    w_sh;
    logic signed [c_sum_w-1:0]   w_sum;
    logic                        w_clip_hi;
    logic                        w_clip_lo;
    logic signed [OUT_WIDTH-1:0] w_res;
    logic        [LEN_WIDTH-1:0] w_last_idx;
    logic                        w_last;

    assign w_s2_adv = !r_s2_valid || ready_i;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_in_hs  = valid_i && w_s1_adv;
    assign w_out_hs = r_s2_valid && ready_i;
    assign ready_o  = w_s1_adv;
    assign valid_o  = r_s2_valid;

    // Both operands widened to the product width; mult is zero-extended.
    assign w_prod = $signed({{9{data_i[IN_WIDTH-1]}}, data_i})
                  * $signed({{IN_WIDTH{1'b0}}, mult_i});

    // One guard bit above the product keeps the rounding add exact.
    always_comb begin
        w_ext = {r_s1_prod[c_prod_w-1], r_s1_prod};
        w_rnd = '0;
        if (r_s1_shift != 5'd0) begin
            w_rnd = c_one << (r_s1_shift - 5'd1);
        end
        w_rsum    = w_ext + w_rnd;
        w_sh      = w_rsum >>> r_s1_shift;
        w_sum     = {w_sh[c_prod_w], w_sh}
                  + {{(c_sum_w - 8){r_s1_add[7]}}, r_s1_add};
        w_clip_hi = w_sum > c_max;
        w_clip_lo = w_sum < c_min;
        if (w_clip_hi) begin
            w_res = c_max[OUT_WIDTH-1:0];
        end else if (w_clip_lo) begin
            w_res = c_min[OUT_WIDTH-1:0];
        end else begin
            w_res = w_sum[OUT_WIDTH-1:0];
        end
    end

    // A zero tile length behaves as a one-beat tile.
    assign w_last_idx = (tile_len_i == '0) ? '0 : tile_len_i - 1'b1;
    assign w_last     = (r_cnt == w_last_idx);

    assign data_o = r_s2_valid ? r_s2_data : '0;
    assign last_o = r_s2_valid && w_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= valid_i;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_out_hs) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    // Payload registers carry no reset; they are qualified by the valid bits.
    always_ff @(posedge clk_i) begin
        if (w_in_hs) begin
            r_s1_prod  <= w_prod;
            r_s1_shift <= shift_i;
            r_s1_add   <= add_i;
        end
        if (w_s2_adv && r_s1_valid) begin
            r_s2_data <= w_res;
        end
    end

`ifdef ITA_GELU_REQUANT_SAT_COUNT_EN
    logic        r_s2_clip;
    logic [15:0] r_sat_cnt;

    always_ff @(posedge clk_i) begin
        if (w_s2_adv && r_s1_valid) begin
            r_s2_clip <= w_clip_hi || w_clip_lo;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sat_cnt <= '0;
        end else if (w_out_hs && r_s2_clip && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_count_o = r_sat_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ita_gelu_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_ita_gelu_requant
// Purpose  : Directed bench for ita_gelu_requant with an arithmetic reference
//            model and per-cycle output comparison.
// Revision : 1.0  initial release
// ============================================================================
module tb_ita_gelu_requant;

    localparam int IW = 26;
    localparam int OW = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b1;
    logic [IW-1:0] data_i = '0;
    logic [7:0]    mult_i = '0;
    logic [4:0]    shift_i = '0;
    logic [7:0]    add_i = '0;
    logic [LW-1:0] tile_len_i = '0;
    logic          ready_o;
    logic          valid_o;
    logic [OW-1:0] data_o;
    logic          last_o;
`ifdef ITA_GELU_REQUANT_SAT_COUNT_EN
    logic [15:0]   sat_count_o;
`endif

    ita_gelu_requant #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .mult_i     (mult_i),
        .shift_i    (shift_i),
        .add_i      (add_i),
        .tile_len_i (tile_len_i),
`ifdef ITA_GELU_REQUANT_SAT_COUNT_EN
        .sat_count_o(sat_count_o),
`endif
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .last_o     (last_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int bp = 0;          // 0: ready high, 1: 1,0,0,1 pattern, 2: ready low
    int out_cnt = 0;
    int mcnt = 0;
    int sat_exp = 0;
    logic [31:0] last_hist = '0;
    logic [OW-1:0] exp_q[$];
    bit            clip_q[$];
    bit            prev_stall = 1'b0;
    logic [OW-1:0] prev_d = '0;
    logic          prev_l = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Reference: exact integer arithmetic with floor shift after half-up bias.
    function automatic logic [OW-1:0] model(input longint d, input longint m,
                                            input int s, input longint a,
                                            output bit clip);
        longint p, sh, sum, mx;
        mx  = (longint'(1) <<< (OW - 1)) - 1;
        p   = d * m;
        sh  = (s == 0) ? p : ((p + (longint'(1) <<< (s - 1))) >>> s);
        sum = sh + a;
        clip = (sum > mx) || (sum < -mx - 1);
        if (sum > mx) sum = mx;
        else if (sum < -mx - 1) sum = -mx - 1;
        return OW'(sum);
    endfunction

    always @(negedge clk) begin
        logic [OW-1:0] e;
        bit c;
        longint eff;
        bit el;
        if (rst_i) begin
            exp_q.delete();
            clip_q.delete();
            mcnt = 0;
            sat_exp = 0;
            prev_stall = 1'b0;
        end else begin
`ifdef ITA_GELU_REQUANT_SAT_COUNT_EN
            chk("sat_count", sat_count_o, sat_exp);
`endif
            chk("ready_o", ready_o, (exp_q.size() < 2) || ready_i);
            if (prev_stall) begin
                chk("stall_valid", valid_o, 1);
                chk("stall_data", data_o, prev_d);
                chk("stall_last", last_o, prev_l);
            end
            if (!valid_o) begin
                chk("idle_data", data_o, 0);
                chk("idle_last", last_o, 0);
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0d required=none", $signed(data_o));
                end else begin
                    e = exp_q.pop_front();
                    c = clip_q.pop_front();
                    chk("data", $signed(data_o), $signed(e));
                    eff = (tile_len_i == 0) ? 1 : longint'(tile_len_i);
                    el  = (mcnt == eff - 1);
                    chk("last", last_o, el);
                    mcnt = el ? 0 : mcnt + 1;
                    if (c && sat_exp < 65535) sat_exp++;
                    out_cnt++;
                    last_hist = {last_hist[30:0], last_o};
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_d = data_o;
            prev_l = last_o;
            if (valid_i && ready_o) begin
                e = model(longint'($signed(data_i)), longint'(mult_i), int'(shift_i),
                          longint'($signed(add_i)), c);
                exp_q.push_back(e);
                clip_q.push_back(c);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        case (bp)
            1:       ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2:       ready_i = 1'b0;
            default: ready_i = 1'b1;
        endcase
    endtask

    task automatic send(input logic [IW-1:0] d, input logic [7:0] m,
                        input logic [4:0] s, input logic [7:0] a);
        bit acc;
        data_i = d; mult_i = m; shift_i = s; add_i = a; valid_i = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = ready_o;
            step();
            if (acc) return;
        end
        fail_now("send_timeout");
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) step();
        if (exp_q.size() != 0) fail_now("drain_timeout");
        step();
    endtask

    // One beat with ready high: invisible after one cycle, visible after two.
    task automatic single(input string name, input logic [IW-1:0] d, input logic [7:0] m,
                          input logic [4:0] s, input logic [7:0] a, input longint exp);
        send(d, m, s, a);
        valid_i = 1'b0;
        chk({name, "_early"}, valid_o, 0);
        step();
        chk({name, "_valid"}, valid_o, 1);
        chk(name, $signed(data_o), exp);
    endtask

    initial begin
        int base;
        tile_len_i = '0;
        repeat (3) step();
        rst_i = 1'b0;
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_data", data_o, 0);

        single("basic_pos",  IW'(100),    8'd3,   5'd4, 8'(-5), 14);
        single("basic_neg",  IW'(-100),   8'd3,   5'd4, 8'd0,   -19);
        single("shift0",     IW'(-7),     8'd1,   5'd0, 8'd0,   -7);
        single("sat_hi",     IW'(100000), 8'd255, 5'd0, 8'd0,   127);
        single("sat_lo",     IW'(-100000),8'd255, 5'd0, 8'd0,   -128);
        step();
`ifdef ITA_GELU_REQUANT_SAT_COUNT_EN
        chk("sat_after_two", sat_count_o, 2);
`endif
        drain();

        base = out_cnt;
        bp = 1;
        for (int i = 0; i < 10; i++)
            send(IW'(i * 1234 - 5000), 8'(17 + i * 20), 5'(i + 2), 8'(i * 7 - 30));
        valid_i = 1'b0;
        drain();
        bp = 0;
        step();
        chk("bp_count", out_cnt - base, 10);

        tile_len_i = LW'(4);
        for (int i = 0; i < 9; i++) send(IW'(i * 10), 8'd1, 5'd0, 8'd0);
        valid_i = 1'b0;
        drain();
        chk("tile4_pattern", last_hist[8:0], 9'b000100010);

        bp = 2;
        step();
        send(IW'(55), 8'd2, 5'd1, 8'd1);
        send(IW'(66), 8'd2, 5'd1, 8'd1);
        valid_i = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        bp = 0;
        ready_i = 1'b1;
        chk("midrst_valid", valid_o, 0);
        chk("midrst_ready", ready_o, 1);
`ifdef ITA_GELU_REQUANT_SAT_COUNT_EN
        chk("midrst_sat", sat_count_o, 0);
`endif
        base = out_cnt;
        repeat (4) step();
        chk("midrst_no_output", out_cnt - base, 0);

        tile_len_i = '0;
        send(IW'(3), 8'd1, 5'd0, 8'd0);
        send(IW'(4), 8'd1, 5'd0, 8'd0);
        valid_i = 1'b0;
        drain();
        chk("tile0_pattern", last_hist[1:0], 2'b11);

        base = out_cnt;
        for (int i = 0; i < 64; i++)
            send(IW'($urandom), 8'($urandom), 5'($urandom_range(0, 31)), 8'($urandom));
        valid_i = 1'b0;
        step();
        step();
        chk("b2b_count", out_cnt - base, 64);
        chk("b2b_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
